// File: rtl/fifo_data_gen.sv
// Bus-programmed 32-bit test-pattern source (counter or Galois LFSR) feeding a show-ahead FIFO input.
// Pops take effect on the clock edge; back-to-back pops yield one word per cycle; bus reads are registered.
module fifo_data_gen #(
  parameter int                   ABUSWIDTH = 16,
  parameter logic [ABUSWIDTH-1:0] BASEADDR  = 16'h0000,
  parameter logic [ABUSWIDTH-1:0] HIGHADDR  = 16'h0000
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [7:0]           BUS_DATA,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ABUSWIDTH-1:0] NREGS   = 15;
  localparam logic [7:0]           VERSION = 8'd1;
  localparam logic [31:0]          TAPS    = 32'h80200003;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [31:0] sent_q, sent_d;
  logic [1:0]  conf_q, conf_d;
  logic [31:0] count_q, count_d;
  logic [31:0] seed_q, seed_d;
  logic        run_mode_q, run_mode_d;
  logic        run_cont_q, run_cont_d;
  logic [31:0] run_count_q, run_count_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_oe_q, rd_oe_d;

  logic                 addr_hit;
  logic [ABUSWIDTH-1:0] offs;
  logic [3:0]           sel;
  logic                 wr_en, soft_rst, rst, start, stop, xfer;

  function automatic logic [31:0] advance(input logic lfsr, input logic [31:0] d);
    if (lfsr) return (d >> 1) ^ (d[0] ? TAPS : 32'h0);
    return d + 32'd1;
  endfunction

  assign addr_hit = (BUS_ADD >= BASEADDR) && (BUS_ADD <= HIGHADDR);
  assign offs     = BUS_ADD - BASEADDR;
  // Offset 15 and above fold onto one "unmapped" selector that reads 0.
  assign sel      = (addr_hit && (offs < NREGS)) ? offs[3:0] : 4'hF;
  assign wr_en    = BUS_WR && addr_hit;
  assign soft_rst = wr_en && (sel == 4'd0);
  assign rst      = BUS_RST || soft_rst;
  assign start    = wr_en && (sel == 4'd1) && BUS_DATA[0];
  assign stop     = wr_en && (sel == 4'd1) && BUS_DATA[1];

  assign FIFO_EMPTY = (state_q != RUN);
  assign FIFO_DATA  = data_q;
  assign xfer       = FIFO_READ && !FIFO_EMPTY;
  assign BUS_DATA   = rd_oe_q ? rd_data_q : 8'hzz;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sent_d      = sent_q;
    conf_d      = conf_q;
    count_d     = count_q;
    seed_d      = seed_q;
    run_mode_d  = run_mode_q;
    run_cont_d  = run_cont_q;
    run_count_d = run_count_q;
    rd_data_d   = rd_data_q;
    rd_oe_d     = BUS_RD && addr_hit;

    if (wr_en) begin
      case (sel)
        4'd2:    conf_d         = BUS_DATA[1:0];
        4'd3:    count_d[7:0]   = BUS_DATA;
        4'd4:    count_d[15:8]  = BUS_DATA;
        4'd5:    count_d[23:16] = BUS_DATA;
        4'd6:    count_d[31:24] = BUS_DATA;
        4'd7:    seed_d[7:0]    = BUS_DATA;
        4'd8:    seed_d[15:8]   = BUS_DATA;
        4'd9:    seed_d[23:16]  = BUS_DATA;
        4'd10:   seed_d[31:24]  = BUS_DATA;
        default: ;
      endcase
    end

    case (state_q)
      RUN: begin
        if (xfer) begin
          sent_d = sent_q + 32'd1;
          data_d = advance(run_mode_q, data_q);
          if (!run_cont_q && (sent_q + 32'd1 == run_count_q)) state_d = DONE;
        end
        if (stop) state_d = DONE;
      end
      default: begin
        if (start) begin
          // An all-zero LFSR state would lock up, so it is replaced by 1.
          data_d      = (conf_q[0] && (seed_q == 32'h0)) ? 32'h1 : seed_q;
          sent_d      = 32'h0;
          run_mode_d  = conf_q[0];
          run_cont_d  = conf_q[1];
          run_count_d = count_q;
          state_d     = ((count_q == 32'h0) && !conf_q[1]) ? DONE : RUN;
        end
      end
    endcase

    if (BUS_RD) begin
      case (sel)
        4'd0:    rd_data_d = VERSION;
        4'd1:    rd_data_d = {6'd0, state_q == RUN, state_q == DONE};
        4'd2:    rd_data_d = {6'd0, conf_q};
        4'd3:    rd_data_d = count_q[7:0];
        4'd4:    rd_data_d = count_q[15:8];
        4'd5:    rd_data_d = count_q[23:16];
        4'd6:    rd_data_d = count_q[31:24];
        4'd7:    rd_data_d = seed_q[7:0];
        4'd8:    rd_data_d = seed_q[15:8];
        4'd9:    rd_data_d = seed_q[23:16];
        4'd10:   rd_data_d = seed_q[31:24];
        4'd11:   rd_data_d = sent_q[7:0];
        4'd12:   rd_data_d = sent_q[15:8];
        4'd13:   rd_data_d = sent_q[23:16];
        4'd14:   rd_data_d = sent_q[31:24];
        default: rd_data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= 32'h0;
      sent_q      <= 32'h0;
      conf_q      <= 2'b00;
      count_q     <= 32'h0;
      seed_q      <= 32'h0;
      run_mode_q  <= 1'b0;
      run_cont_q  <= 1'b0;
      run_count_q <= 32'h0;
      rd_data_q   <= 8'h00;
      rd_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sent_q      <= sent_d;
      conf_q      <= conf_d;
      count_q     <= count_d;
      seed_q      <= seed_d;
      run_mode_q  <= run_mode_d;
      run_cont_q  <= run_cont_d;
      run_count_q <= run_count_d;
      rd_data_q   <= rd_data_d;
      rd_oe_q     <= rd_oe_d;
    end
  end

endmodule

// File: tb/tb_fifo_data_gen.sv
// Directed bench: bus register checks inline, emitted FIFO words checked by a scoreboard monitor.
module tb_fifo_data_gen;

  logic        clk = 1'b0;
  logic        bus_rst = 1'b1;
  logic [15:0] bus_add = 16'h0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_wdat = 8'h0;
  wire  [7:0]  bus_data;
  logic        fifo_read = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_data;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  assign bus_data = bus_wr ? bus_wdat : 8'hzz;

  always #5 clk = ~clk;

  fifo_data_gen #(
    .ABUSWIDTH(16),
    .BASEADDR (16'h0000),
    .HIGHADDR (16'h000F)
  ) dut (
    .BUS_CLK   (clk),
    .BUS_RST   (bus_rst),
    .BUS_ADD   (bus_add),
    .BUS_DATA  (bus_data),
    .BUS_RD    (bus_rd),
    .BUS_WR    (bus_wr),
    .FIFO_READ (fifo_read),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA (fifo_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // A pop happens at the next rising edge whenever read is high and empty is low.
  always @(negedge clk) begin
    if (!bus_rst && fifo_read && !fifo_empty) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", fifo_data, 32'hDEADBEEF);
      end else begin
        check("fifo_word", fifo_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_add  = a;
    bus_wdat = d;
    bus_wr   = 1'b1;
    tick();
    bus_wr   = 1'b0;
  endtask

  task automatic wr32(input logic [15:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) wr(a + 16'(i), d[8*i +: 8]);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus_add = a;
    bus_rd  = 1'b1;
    tick();
    d       = bus_data;
    bus_rd  = 1'b0;
  endtask

  task automatic rd32(input logic [15:0] a, output logic [31:0] d);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      rd(a + 16'(i), b);
      d[8*i +: 8] = b;
    end
  endtask

  task automatic drain(input string name, input bit toggle);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      if (toggle) fifo_read = ~fifo_read;
      tick();
    end
    fifo_read = 1'b0;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w;

    repeat (3) tick();
    bus_rst = 1'b0;
    check("rst_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_data", fifo_data, 32'h0);
    rd(16'd0, b);
    check("version", {24'd0, b}, 32'd1);
    for (int i = 1; i <= 14; i++) begin
      rd(16'(i), b);
      check($sformatf("rst_reg%0d", i), {24'd0, b}, 32'd0);
    end
    rd(16'd20, b);
    check("unmapped", {24'd0, b}, 32'd0);

    // Counter mode wrapping through zero, read held high.
    wr(16'd2, 8'h00);
    wr32(16'd3, 32'd4);
    wr32(16'd7, 32'hFFFFFFFE);
    wr32(16'd3, 32'd4);
    exp_q.push_back(32'hFFFFFFFE);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000001);
    fifo_read = 1'b1;
    wr(16'd1, 8'h01);
    check("start_not_empty", {31'd0, fifo_empty}, 32'd0);
    check("start_data", fifo_data, 32'hFFFFFFFE);
    drain("cnt_drain", 1'b0);
    check("cnt_empty", {31'd0, fifo_empty}, 32'd1);
    rd(16'd1, b);
    check("cnt_status", {24'd0, b}, 32'h01);
    rd32(16'd11, w);
    check("cnt_sent", w, 32'd4);

    // LFSR mode with zero seed, read held then toggled.
    wr(16'd2, 8'h01);
    wr32(16'd7, 32'h0);
    wr32(16'd3, 32'd3);
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back(32'h00000001);
      exp_q.push_back(32'h80200003);
      exp_q.push_back(32'hC0300002);
      fifo_read = (pass == 0);
      wr(16'd1, 8'h01);
      drain("lfsr_drain", pass == 1);
      rd(16'd1, b);
      check("lfsr_status", {24'd0, b}, 32'h01);
      rd32(16'd11, w);
      check("lfsr_sent", w, 32'd3);
    end

    // COUNT==0 finishes without emitting anything.
    wr(16'd2, 8'h00);
    wr32(16'd3, 32'd0);
    fifo_read = 1'b1;
    wr(16'd1, 8'h01);
    check("cnt0_empty", {31'd0, fifo_empty}, 32'd1);
    rd(16'd1, b);
    check("cnt0_status", {24'd0, b}, 32'h01);
    fifo_read = 1'b0;
    rd32(16'd11, w);
    check("cnt0_sent", w, 32'd0);

    // Continuous mode, STOP in the same cycle as the 11th pop.
    wr(16'd2, 8'h02);
    wr32(16'd7, 32'd0);
    for (int i = 0; i <= 10; i++) exp_q.push_back(32'(i));
    wr(16'd1, 8'h01);
    fifo_read = 1'b1;
    repeat (10) tick();
    wr(16'd1, 8'h02);
    fifo_read = 1'b0;
    check("stop_empty", {31'd0, fifo_empty}, 32'd1);
    check("stop_queue", 32'(exp_q.size()), 32'd0);
    rd(16'd1, b);
    check("stop_status", {24'd0, b}, 32'h01);
    rd32(16'd11, w);
    check("stop_sent", w, 32'd11);

    // Long counter run with irregular pops.
    wr(16'd2, 8'h00);
    wr32(16'd3, 32'd1000);
    for (int i = 0; i < 1000; i++) exp_q.push_back(32'(i));
    wr(16'd1, 8'h01);
    for (int c = 0; c < 5000 && exp_q.size() > 0; c++) begin
      fifo_read = 1'($urandom_range(0, 1));
      tick();
    end
    fifo_read = 1'b0;
    check("long_queue", 32'(exp_q.size()), 32'd0);
    check("long_empty", {31'd0, fifo_empty}, 32'd1);
    rd32(16'd11, w);
    check("long_sent", w, 32'd1000);

    // START during RUN is ignored; soft reset aborts the run.
    wr32(16'd3, 32'd100);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i));
    wr(16'd1, 8'h01);
    fifo_read = 1'b1;
    repeat (3) tick();
    wr(16'd1, 8'h01);
    tick();
    fifo_read = 1'b0;
    check("restart_queue", 32'(exp_q.size()), 32'd0);
    check("restart_data", fifo_data, 32'd5);
    rd(16'd1, b);
    check("run_status", {24'd0, b}, 32'h02);
    wr(16'd0, 8'h5A);
    check("srst_empty", {31'd0, fifo_empty}, 32'd1);
    check("srst_data", fifo_data, 32'h0);
    rd32(16'd11, w);
    check("srst_sent", w, 32'd0);
    rd32(16'd3, w);
    check("srst_count", w, 32'd0);
    rd(16'd1, b);
    check("srst_status", {24'd0, b}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
